// File: rtl/dac_tone_gen.sv
// dac_tone_gen
//   Direct-digital-synthesis tone source for the RFDC DAC AXI4-Stream input.
//   Produces NSAMP amplitude-scaled sine samples per beat, either continuously
//   or as a counted burst, through a four-stage stall-able pipeline.
//
// Ports
//   i_clk, i_rst         stream clock, synchronous active-high reset
//   i_cfg_wr/addr/data   single-cycle register write
//                        0 FTW, 1 AMP (Q1.15), 2 BURST (0 = continuous),
//                        3 CTRL (bit0 enable, bit1 restart)
//   m_axis_tdata         NSAMP x SW samples, sample 0 (earliest) in the LSBs
//   m_axis_tvalid/tready stream handshake
//   o_busy               a tone is being issued or beats are still in flight
//   o_done               pulses with the acceptance of the last burst beat
module dac_tone_gen #(
  parameter int NSAMP  = 8,
  parameter int SW     = 16,
  parameter int PW     = 32,
  parameter int LUT_AW = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cfg_wr,
  input  logic [1:0]            i_cfg_addr,
  input  logic [31:0]           i_cfg_data,
  output logic [NSAMP*SW-1:0]   m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int LUT_DEPTH = 1 << LUT_AW;
  localparam int PRODW     = 2 * SW + 1;
  localparam logic [SW-1:0]          AMP_ONE = SW'(1) << (SW - 1);
  localparam logic signed [PRODW-1:0] RND    = PRODW'(1) <<< (SW - 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_reg, state_next;
  logic   drain_burst_reg, drain_burst_next;

  logic [PW-1:0] ftw_reg, ftw_sh_reg, acc_reg;
  logic [SW-1:0] amp_reg, amp_sh_reg;
  logic [31:0]   burst_reg, burst_sh_reg, count_reg;
  logic          enable_reg;

  logic                    v1_reg, v2_reg, v3_reg, v4_reg;
  logic [SW-1:0]           amp1_reg, amp2_reg;
  logic [LUT_AW-1:0]       idx1_reg  [NSAMP];
  logic signed [SW-1:0]    lut2_reg  [NSAMP];
  logic signed [PRODW-1:0] prod3_reg [NSAMP];
  logic [SW-1:0]           out_reg   [NSAMP];
  logic signed [SW-1:0]    sine_rom  [LUT_DEPTH];

  logic adv, ctrl_wr, restart_wr, disable_wr, start, issue, last_issue, empty_next, done;

  // Full-wave table entry, rounded half away from zero.
  function automatic logic signed [SW-1:0] sine_entry(input int idx);
    real x;
    x = real'((1 << (SW - 1)) - 1) * $sin(2.0 * 3.14159265358979323846 * real'(idx) / real'(LUT_DEPTH));
    if (x >= 0.0) return SW'($rtoi(x + 0.5));
    else          return SW'($rtoi(x - 0.5));
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
      assign sine_rom[gi] = sine_entry(gi);
    end
    for (gi = 0; gi < NSAMP; gi++) begin : g_lane
      assign m_axis_tdata[gi*SW +: SW] = out_reg[gi];
    end
  endgenerate

  assign adv        = !v4_reg || m_axis_tready;
  assign ctrl_wr    = i_cfg_wr && (i_cfg_addr == 2'd3);
  assign restart_wr = ctrl_wr && i_cfg_data[1];
  assign disable_wr = ctrl_wr && !i_cfg_data[0] && !i_cfg_data[1] && enable_reg;
  assign start      = restart_wr || (ctrl_wr && i_cfg_data[0] && (state_reg == IDLE));
  // A restart cycle issues nothing: the next beat must start from phase 0.
  assign issue      = (state_reg == RUN) && adv && !restart_wr;
  assign last_issue = issue && (burst_sh_reg != 32'd0) && (count_reg + 32'd1 == burst_sh_reg);
  // Pipeline will be empty after this edge (S4 leaves only when accepted).
  assign empty_next = adv ? !(v1_reg || v2_reg || v3_reg)
                          : !(v1_reg || v2_reg || v3_reg || v4_reg);

  always_comb begin
    state_next       = state_reg;
    drain_burst_next = drain_burst_reg;
    done             = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next       = RUN;
          drain_burst_next = 1'b0;
        end
      end
      RUN: begin
        if (restart_wr) begin
          drain_burst_next = 1'b0;
        end else if (last_issue) begin
          state_next       = DRAIN;
          drain_burst_next = 1'b1;
        end else if (disable_wr) begin
          state_next       = DRAIN;
          drain_burst_next = 1'b0;
        end
      end
      DRAIN: begin
        if (restart_wr) begin
          state_next       = RUN;
          drain_burst_next = 1'b0;
        end else if (empty_next) begin
          state_next = IDLE;
          done       = drain_burst_reg && v4_reg && m_axis_tready;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg       <= IDLE;
      drain_burst_reg <= 1'b0;
      ftw_reg         <= '0;
      amp_reg         <= AMP_ONE;
      burst_reg       <= '0;
      enable_reg      <= 1'b0;
      ftw_sh_reg      <= '0;
      amp_sh_reg      <= AMP_ONE;
      burst_sh_reg    <= '0;
      acc_reg         <= '0;
      count_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      drain_burst_reg <= drain_burst_next;
      if (i_cfg_wr) begin
        case (i_cfg_addr)
          2'd0:    ftw_reg   <= PW'(i_cfg_data);
          2'd1:    amp_reg   <= i_cfg_data[SW-1:0];
          2'd2:    burst_reg <= i_cfg_data;
          default: ;
        endcase
      end
      // A restart also (re)enables; completing a drain clears enable.
      if (state_reg == DRAIN && state_next == IDLE) enable_reg <= 1'b0;
      else if (ctrl_wr)                             enable_reg <= i_cfg_data[0] | i_cfg_data[1];
      if (start) begin
        ftw_sh_reg   <= ftw_reg;
        amp_sh_reg   <= (amp_reg > AMP_ONE) ? AMP_ONE : amp_reg;
        burst_sh_reg <= burst_reg;
        acc_reg      <= '0;
        count_reg    <= '0;
      end else if (issue) begin
        acc_reg   <= acc_reg + ftw_sh_reg * PW'(NSAMP);
        count_reg <= count_reg + 32'd1;
      end
    end
  end

  // Pipeline. S1 keeps only the LUT-index bits of each sample phase; the
  // amplitude travels with the beat so a restart cannot rescale beats in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_reg   <= 1'b0;
      v2_reg   <= 1'b0;
      v3_reg   <= 1'b0;
      v4_reg   <= 1'b0;
      amp1_reg <= '0;
      amp2_reg <= '0;
      for (int k = 0; k < NSAMP; k++) begin
        idx1_reg[k]  <= '0;
        lut2_reg[k]  <= '0;
        prod3_reg[k] <= '0;
        out_reg[k]   <= '0;
      end
    end else if (adv) begin
      v1_reg   <= issue;
      v2_reg   <= v1_reg;
      v3_reg   <= v2_reg;
      v4_reg   <= v3_reg;
      amp1_reg <= amp_sh_reg;
      amp2_reg <= amp1_reg;
      for (int k = 0; k < NSAMP; k++) begin
        idx1_reg[k]  <= LUT_AW'((acc_reg + PW'(k) * ftw_sh_reg) >> (PW - LUT_AW));
        lut2_reg[k]  <= sine_rom[idx1_reg[k]];
        prod3_reg[k] <= PRODW'(lut2_reg[k]) * PRODW'($signed({1'b0, amp2_reg}));
        out_reg[k]   <= SW'((prod3_reg[k] + RND) >>> (SW - 1));
      end
    end
  end

  assign m_axis_tvalid = v4_reg;
  assign o_busy        = (state_reg != IDLE);
  assign o_done        = done;

endmodule

// File: tb/tb_dac_tone_gen.sv
// Self-checking bench for dac_tone_gen: table-driven tone vectors plus
// hand-written burst, continuity, disable, restart and reset sequences.
module tb_dac_tone_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_wr;
  logic [1:0]   cfg_addr;
  logic [31:0]  cfg_data;
  logic [127:0] tdata;
  logic         tvalid, tready, busy, done;

  int checks = 0;
  int errors = 0;
  int sine_tab [1024];

  typedef struct packed {
    logic [31:0]  ftw;
    logic [31:0]  amp;
    logic [127:0] exp_even;
    logic [127:0] exp_odd;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  dac_tone_gen dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cfg_wr      (cfg_wr),
    .i_cfg_addr    (cfg_addr),
    .i_cfg_data    (cfg_data),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .o_busy        (busy),
    .o_done        (done)
  );

  function automatic logic [127:0] pack8(input int s0, s1, s2, s3, s4, s5, s6, s7);
    return {16'(s7), 16'(s6), 16'(s5), 16'(s4), 16'(s3), 16'(s2), 16'(s1), 16'(s0)};
  endfunction

  // Reference beat: p_k = acc + k*ftw, LUT on the top 10 bits, Q1.15 scaling with rounding.
  function automatic logic [127:0] model_beat(input logic [31:0] acc, input logic [31:0] ftw, input int amp);
    logic [127:0] v;
    logic [31:0]  p;
    longint       r;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      p = acc + 32'(k) * ftw;
      r = (longint'(sine_tab[p[31:22]]) * longint'(amp) + 64'sd16384) >>> 15;
      v[16*k +: 16] = r[15:0];
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs change at the falling edge, outputs are read 1 ns later.
  task automatic cyc(input logic rdy);
    @(negedge clk);
    tready = rdy;
    cfg_wr = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    tready   = rdy;
    cfg_wr   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      cyc(1'b1);
      n++;
    end while (!tvalid && n < 10);
    check({name, " first valid"}, 128'(tvalid), 128'(1));
  endtask

  task automatic stop_and_drain(input string name);
    int n;
    int nd;
    n  = 0;
    nd = 0;
    wr(2'd3, 32'd0, 1'b1);
    while (busy && n < 30) begin
      cyc(1'b1);
      if (done) nd++;
      n++;
    end
    check({name, " drain idle"}, 128'(busy), 128'(0));
    check({name, " drain no done"}, 128'(nd), 128'(0));
  endtask

  initial begin
    real x;
    int ntx, nd, nold;
    logic prev_stall;
    logic [127:0] prev_data, exp_b;
    logic [31:0] macc;

    for (int i = 0; i < 1024; i++) begin
      x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * i / 1024.0);
      sine_tab[i] = (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
    end

    vecs[0] = '{32'h2000_0000, 32'h8000,
                pack8(0, 23170, 32767, 23170, 0, -23170, -32767, -23170),
                pack8(0, 23170, 32767, 23170, 0, -23170, -32767, -23170)};
    vecs[1] = '{32'h2000_0000, 32'h4000,
                pack8(0, 11585, 16384, 11585, 0, -11585, -16383, -11585),
                pack8(0, 11585, 16384, 11585, 0, -11585, -16383, -11585)};
    vecs[2] = '{32'h2000_0000, 32'hFFFF,   // clamped to 0x8000
                pack8(0, 23170, 32767, 23170, 0, -23170, -32767, -23170),
                pack8(0, 23170, 32767, 23170, 0, -23170, -32767, -23170)};
    vecs[3] = '{32'h4000_0000, 32'h8000,
                pack8(0, 32767, 0, -32767, 0, 32767, 0, -32767),
                pack8(0, 32767, 0, -32767, 0, 32767, 0, -32767)};
    vecs[4] = '{32'h1000_0000, 32'h8000,
                pack8(0, 12539, 23170, 30273, 32767, 30273, 23170, 12539),
                pack8(0, -12539, -23170, -30273, -32767, -30273, -23170, -12539)};

    rst = 1'b1; tready = 1'b0; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_data = 32'd0;
    repeat (3) cyc(1'b0);
    @(negedge clk); rst = 1'b0; #1;
    check("reset tvalid", 128'(tvalid), 128'(0));
    check("reset tdata", tdata, 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    check("reset done", 128'(done), 128'(0));

    // Continuous tones: 4-cycle latency, then beats alternate even/odd patterns.
    for (int v = 0; v < 5; v++) begin
      wr(2'd0, vecs[v].ftw, 1'b1);
      wr(2'd1, vecs[v].amp, 1'b1);
      wr(2'd2, 32'd0, 1'b1);
      wr(2'd3, 32'd1, 1'b1);
      for (int c = 1; c <= 5; c++) begin
        cyc(1'b1);
        check($sformatf("tone%0d latency c%0d", v, c), 128'(tvalid), 128'(c == 5));
      end
      for (int b = 0; b < 4; b++) begin
        if (b > 0) cyc(1'b1);
        $display("txn tone%0d beat%0d valid=%0b data=%h", v, b, tvalid, tdata);
        check($sformatf("tone%0d beat%0d", v, b), tdata,
              (b % 2 == 1) ? vecs[v].exp_odd : vecs[v].exp_even);
      end
      stop_and_drain($sformatf("tone%0d", v));
    end

    // Burst of 3 under random backpressure.
    wr(2'd0, 32'h1000_0000, 1'b0);
    wr(2'd1, 32'h8000, 1'b0);
    wr(2'd2, 32'd3, 1'b0);
    wr(2'd3, 32'd1, 1'b0);
    ntx = 0; nd = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 80; c++) begin
      cyc(1'($urandom_range(0, 1)));
      if (prev_stall) begin
        check("burst hold valid", 128'(tvalid), 128'(1));
        check("burst hold data", tdata, prev_data);
      end
      if (done) nd++;
      if (tvalid && tready) begin
        $display("txn burst beat%0d data=%h done=%0b", ntx, tdata, done);
        check($sformatf("burst beat%0d", ntx), tdata, (ntx % 2 == 1) ? vecs[4].exp_odd : vecs[4].exp_even);
        ntx++;
        check($sformatf("burst done at beat%0d", ntx), 128'(done), 128'(ntx == 3));
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
    end
    check("burst transfers", 128'(ntx), 128'(3));
    check("burst done pulses", 128'(nd), 128'(1));
    check("burst busy low", 128'(busy), 128'(0));
    wr(2'd2, 32'd0, 1'b0);

    // Phase continuity against the reference model under random tready.
    wr(2'd0, 32'h0123_4567, 1'b1);
    wr(2'd1, 32'h6000, 1'b1);
    wr(2'd3, 32'd1, 1'b1);
    macc = 32'd0; ntx = 0;
    for (int c = 0; c < 400 && ntx < 100; c++) begin
      cyc(1'($urandom_range(0, 1)));
      if (tvalid && tready) begin
        exp_b = model_beat(macc, 32'h0123_4567, 32'h6000);
        $display("txn cont beat%0d data=%h", ntx, tdata);
        check($sformatf("cont beat%0d", ntx), tdata, exp_b);
        macc = macc + 32'd8 * 32'h0123_4567;
        ntx++;
      end
    end
    check("cont transfers", 128'(ntx), 128'(100));
    stop_and_drain("cont");

    // Disable during a stall: the four in-flight beats still drain, no done.
    wr(2'd0, 32'h2000_0000, 1'b1);
    wr(2'd1, 32'h8000, 1'b1);
    wr(2'd3, 32'd1, 1'b1);
    wait_valid("dis");
    cyc(1'b1); cyc(1'b1);
    cyc(1'b0); cyc(1'b0);
    wr(2'd3, 32'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      cyc(1'b0);
      check($sformatf("dis stall valid c%0d", c), 128'(tvalid), 128'(1));
      check($sformatf("dis stall busy c%0d", c), 128'(busy), 128'(1));
    end
    ntx = 0; nd = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1);
      if (done) nd++;
      if (tvalid) begin
        $display("txn dis beat%0d data=%h", ntx, tdata);
        check($sformatf("dis beat%0d", ntx), tdata, vecs[0].exp_even);
        ntx++;
      end
    end
    check("dis transfers", 128'(ntx), 128'(4));
    check("dis no done", 128'(nd), 128'(0));
    check("dis busy low", 128'(busy), 128'(0));

    // Restart while running: old beats finish, one bubble, then the new phase-0 beat.
    wr(2'd0, 32'h1000_0000, 1'b1);
    wr(2'd3, 32'd1, 1'b1);
    wait_valid("rst0");
    nold = 0;
    check("restart old beat0", tdata, vecs[4].exp_even);
    nold++;
    for (int c = 0; c < 5; c++) begin
      case (c)
        2:       wr(2'd0, 32'h4000_0000, 1'b1);
        4:       wr(2'd3, 32'd3, 1'b1);
        default: cyc(1'b1);
      endcase
      check($sformatf("restart old beat%0d", nold), tdata, (nold % 2 == 1) ? vecs[4].exp_odd : vecs[4].exp_even);
      nold++;
    end
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b1);
      $display("txn restart c%0d valid=%0b data=%h", c, tvalid, tdata);
      if (c <= 3)
        check($sformatf("restart inflight beat%0d", nold + c - 1), tdata,
              ((nold + c - 1) % 2 == 1) ? vecs[4].exp_odd : vecs[4].exp_even);
      else if (c == 4)
        check("restart bubble", 128'(tvalid), 128'(0));
      else begin
        check($sformatf("restart new valid c%0d", c), 128'(tvalid), 128'(1));
        check($sformatf("restart new beat c%0d", c), tdata, vecs[3].exp_even);
      end
    end
    stop_and_drain("restart");

    // Reset during a stalled burst, then defaults (AMP 0x8000, BURST 0).
    wr(2'd0, 32'h2000_0000, 1'b1);
    wr(2'd1, 32'h4000, 1'b1);
    wr(2'd2, 32'd5, 1'b1);
    wr(2'd3, 32'd1, 1'b1);
    wait_valid("rstb");
    check("rstb beat0", tdata, vecs[1].exp_even);
    cyc(1'b0); cyc(1'b0);
    @(negedge clk); rst = 1'b1; tready = 1'b0; #1;
    @(negedge clk); rst = 1'b0; #1;
    check("rstb tvalid", 128'(tvalid), 128'(0));
    check("rstb busy", 128'(busy), 128'(0));
    check("rstb tdata", tdata, 128'(0));
    check("rstb done", 128'(done), 128'(0));
    wr(2'd0, 32'h2000_0000, 1'b1);
    wr(2'd3, 32'd1, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      cyc(1'b1);
      check($sformatf("rstb latency c%0d", c), 128'(tvalid), 128'(c == 5));
    end
    for (int b = 0; b < 7; b++) begin
      if (b > 0) cyc(1'b1);
      $display("txn rstb beat%0d data=%h", b, tdata);
      check($sformatf("rstb default beat%0d", b), tdata, vecs[0].exp_even);
    end
    check("rstb still busy", 128'(busy), 128'(1));
    stop_and_drain("rstb");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dac_tone_gen.md
# dac_tone_gen

Direct-digital-synthesis tone source feeding the RFDC DAC AXI4-Stream input at eight 16-bit samples per clock. It is the transmit counterpart of the ADC-side Goertzel tone detector: it produces a programmable, amplitude-scaled sinusoid, either continuous or as a counted burst, so that the DAC-to-ADC loopback can be closed in firmware. Configuration arrives through a simple single-cycle register-write port driven from the PS-side register bank, resynchronised into `i_clk` upstream.

## Interface
Parameters:
- `NSAMP`, 8: samples per beat.
- `SW`, 16: sample width, signed two's complement.
- `PW`, 32: phase accumulator width.
- `LUT_AW`, 10: sine LUT address width. The table is full-wave with 1024 entries; entry k = round(32767·sin(2πk/1024)).

Ports:
- `i_clk`, in, 1: stream clock. The one clock of the block; 375 MHz in the design.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_cfg_wr`, in, 1: register write strobe.
- `i_cfg_addr`, in, 2: register address. 0 = FTW (phase increment per sample); 1 = AMP (unsigned Q1.15, bits [15:0]); 2 = BURST (beats, 0 = continuous); 3 = CTRL (bit0 enable, bit1 restart).
- `i_cfg_data`, in, 32: write data.
- `m_axis_tdata`, out, NSAMP·SW: sample k occupies [16k+15:16k]. Sample 0 is the earliest.
- `m_axis_tvalid`, out, 1: beat valid.
- `m_axis_tready`, in, 1: DAC ready.
- `o_busy`, out, 1: issuing beats or beats still in flight.
- `o_done`, out, 1: one-cycle pulse when the last burst beat is accepted.

## Operation
Registers:
- CTRL bit1 (restart) is self-clearing and reads as 0.
- FTW, AMP and BURST are copied into shadow registers at start. Start is either of:
  - a write that sets enable while idle;
  - a restart write.
- Writes to these registers while running do not affect the tone until the next start.
- At shadow load, AMP > 0x8000 is clamped to 0x8000.

States:
- IDLE: on start, go to RUN; the phase accumulator `acc` resets to 0 and the issued-beat counter to 0.
- RUN: issue one beat per advancing cycle.
  - Phases: p_k = acc + k·FTW; then acc += NSAMP·FTW. All arithmetic is modulo 2^PW.
  - In burst mode, after BURST beats have been issued, go to DRAIN.
  - Writing enable = 0 also goes to DRAIN.
  - A restart write reloads the shadows, zeroes `acc` and the counter, and stays in RUN. Beats already in flight are still delivered.
- DRAIN: no new issue. In-flight beats are delivered under normal handshake.
  - When the pipeline is empty: go to IDLE and clear CTRL.enable.
  - `o_done` pulses in the cycle the final burst beat is accepted. It pulses in burst mode only; it does not pulse on a disable.

Pipeline, four registered stages:
- S1: the NSAMP phases.
- S2: LUT read, index = p_k[PW-1:PW-LUT_AW].
- S3: product lut·AMP, signed 33 bit.
- S4: (product + 0x4000) >>> 15 (arithmetic), taken as 16 bits. This stage drives `m_axis_tdata` and `m_axis_tvalid`.
- With AMP ≤ 0x8000 the result never overflows, so no saturation is needed.

Handshake:
- The global pipeline enable is `adv = !m_axis_tvalid || m_axis_tready`. All stages, `acc` and the counter hold when `adv` = 0.
- While `m_axis_tvalid` = 1 and `m_axis_tready` = 0, `m_axis_tdata` is held stable. `m_axis_tvalid` never deasserts without a transfer.
- `o_busy` = (state != IDLE).

Reset:
- Outputs: `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `o_busy` = 0, `o_done` = 0.
- State: IDLE; `acc` = 0; all stage valids cleared.
- Registers: FTW = 0, AMP = 0x8000, BURST = 0, CTRL = 0.
- Reset applied mid-burst abandons in-flight beats immediately. This is the only case where `tvalid` drops without a handshake.

## Timing
- Config write sampled at edge t. An enabling write issues into S1 at edge t+1. `m_axis_tvalid` is first high after edge t+4, i.e. 4 cycles of latency with `tready` held at 1.
- Sustained throughput is one beat per cycle while `m_axis_tready` = 1.
- Phase is continuous across beats and across stalls: there are no gaps and no repeated phase.
- `o_done` asserts in the same cycle as the final accepted handshake. `o_busy` falls on the next edge.
- A restart and a final acceptance in the same cycle: the restart wins and no `o_done` is issued.

## Test plan
- Tone shape: AMP=0x8000, FTW=0x2000_0000, BURST=0, enable, `tready`=1.
  - Every beat is samples 0, 23170, 32767, 23170, 0, −23170, −32767, −23170.
  - First valid appears 4 cycles after the write.
- Scaling: as above but AMP=0x4000.
  - Beats are 0, 11585, 16384, 11585, 0, −11585, −16383, −11585.
- Burst with backpressure: BURST=3, `tready` pseudo-random at 50%.
  - Exactly 3 transfers occur.
  - `tdata` is stable through stalls.
  - `o_done` is a single pulse on the 3rd transfer.
  - Enable is then cleared and `o_busy` falls.
- Phase continuity: FTW=0x0123_4567, 100 beats under random `tready`.
  - The scoreboard model (acc advancing 8·FTW per beat) matches every sample bit-exactly.
- Disable and restart mid-stream:
  - Write enable=0 with `tready`=0: tvalid stays high until the in-flight beats drain, and there is no `o_done`.
  - Restart while running: the first post-restart beat equals the phase-0 beat.
- Reset mid-burst: assert `i_rst` for 1 cycle during a stall.
  - The next cycle shows tvalid=0, busy=0 and registers at their defaults.
  - A fresh enable reproduces the first test's output.
